// File: rtl/spart_driver_pkg.sv
// -----------------------------------------------------------------------------
// spart_driver_pkg
// Shared definitions for the spart bus master: register addresses on the
// spart bus, the baud-select table, the divisor helper and the FSM encoding.
// -----------------------------------------------------------------------------
package spart_driver_pkg;

  // spart register map (ioaddr)
  localparam logic [1:0] IOADDR_BUF    = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DIV_LO = 2'b10;
  localparam logic [1:0] IOADDR_DIV_HI = 2'b11;

  // Baud rates selected by br_cfg
  localparam int BAUD_4800  = 4800;
  localparam int BAUD_9600  = 9600;
  localparam int BAUD_19200 = 19200;
  localparam int BAUD_38400 = 38400;

  typedef enum logic [2:0] {
    ST_INIT_LO = 3'd0,
    ST_INIT_HI = 3'd1,
    ST_IDLE    = 3'd2,
    ST_READ    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Map the 2-bit baud select onto a baud rate.
  function automatic int baud_rate(input logic [1:0] sel);
    case (sel)
      2'b00:   return BAUD_4800;
      2'b01:   return BAUD_9600;
      2'b10:   return BAUD_19200;
      2'b11:   return BAUD_38400;
      default: return BAUD_9600;
    endcase
  endfunction

  // Divisor for the spart's 16x oversampling clock, integer-truncated.
  function automatic logic [15:0] baud_div(input logic [1:0] sel, input int clk_hz);
    return 16'(clk_hz / (16 * baud_rate(sel)) - 1);
  endfunction

endpackage

// File: rtl/spart_driver_echo_fifo.sv
// -----------------------------------------------------------------------------
// echo_fifo
// DEPTH x 8 FIFO holding received bytes until the spart can transmit them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data   write one byte (ignored when full unless popping too)
//   i_pop            drop the head byte (ignored when empty)
//   o_data           current head byte
//   o_full, o_empty  occupancy flags
// -----------------------------------------------------------------------------
module echo_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  // Same slot index but opposite wrap bit means the writer is a full lap ahead.
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is fine when the same edge frees the head slot.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd[AW-1:0]];

  // Read/write pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/spart_driver.sv
// -----------------------------------------------------------------------------
// spart_driver
// Bus master for the spart: programs the baud divisor selected by br_cfg,
// then echoes every received byte back out through a small FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   br_cfg          baud select (00=4800 01=9600 10=19200 11=38400)
//   iocs/iorw/ioaddr registered spart bus controls (iorw 1=read)
//   databus         bidirectional data; driven only for writes
//   rda, tbr        spart receive-available / transmit-ready flags
// -----------------------------------------------------------------------------
module spart_driver
  import spart_driver_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  state_t      r_state;
  state_t      r_ret;
  logic        r_iocs;
  logic        r_iorw;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_dout;
  logic [1:0]  r_br_q;

  state_t      w_next;
  state_t      w_ret_next;
  state_t      w_arb_next;
  logic        w_capture_br;
  logic        w_push;
  logic        w_pop;
  logic        w_iocs;
  logic        w_iorw;
  logic [1:0]  w_ioaddr;
  logic [7:0]  w_dout;
  logic [15:0] w_div;
  logic [7:0]  w_fifo_head;
  logic        w_full;
  logic        w_empty;

  assign iocs    = r_iocs;
  assign iorw    = r_iorw;
  assign ioaddr  = r_ioaddr;
  assign databus = (r_iocs && !r_iorw) ? r_dout : 8'hzz;

  echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  (databus),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Arbitration among reprogramming, receive and transmit (in priority order).
  always_comb begin
    w_arb_next = ST_IDLE;
    if (br_cfg != r_br_q) begin
      w_arb_next = ST_INIT_LO;
    end else if (rda && !w_full) begin
      w_arb_next = ST_READ;
    end else if (tbr && !w_empty) begin
      w_arb_next = ST_WRITE;
    end else begin
      w_arb_next = ST_IDLE;
    end
  end

  // Next state, FIFO strobes, and the bus values to be registered for the next cycle.
  always_comb begin
    w_next       = r_state;
    w_ret_next   = r_ret;
    w_capture_br = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_iocs       = 1'b0;
    w_iorw       = 1'b1;
    w_ioaddr     = IOADDR_BUF;
    w_dout       = 8'h00;

    case (r_state)
      ST_INIT_LO: begin
        // Straight out of reset the bus is idle, so spend one cycle setting up
        // the low-divisor write; when entered from arbitration it is already on the bus.
        if (r_iocs) begin
          w_next     = ST_GAP;
          w_ret_next = ST_INIT_HI;
        end else begin
          w_next       = ST_INIT_LO;
          w_capture_br = 1'b1;
        end
      end
      ST_INIT_HI: begin
        w_next     = ST_GAP;
        w_ret_next = ST_IDLE;
      end
      ST_READ: begin
        w_push     = 1'b1;
        w_next     = ST_GAP;
        w_ret_next = ST_IDLE;
      end
      ST_WRITE: begin
        w_pop      = 1'b1;
        w_next     = ST_GAP;
        w_ret_next = ST_IDLE;
      end
      ST_GAP: begin
        // A gap returning to IDLE arbitrates itself so back-to-back accesses
        // are exactly two cycles apart.
        if (r_ret == ST_IDLE) begin
          w_next       = w_arb_next;
          w_capture_br = (w_arb_next == ST_INIT_LO);
        end else begin
          w_next = r_ret;
        end
      end
      ST_IDLE: begin
        w_next       = w_arb_next;
        w_capture_br = (w_arb_next == ST_INIT_LO);
      end
      default: begin
        w_next     = ST_INIT_LO;
        w_ret_next = ST_INIT_HI;
      end
    endcase

    // INIT_LO always loads a freshly captured select; INIT_HI reuses the captured one.
    w_div = baud_div((w_next == ST_INIT_LO) ? br_cfg : r_br_q, CLK_HZ);

    case (w_next)
      ST_INIT_LO: begin
        w_iocs   = 1'b1;
        w_iorw   = 1'b0;
        w_ioaddr = IOADDR_DIV_LO;
        w_dout   = w_div[7:0];
      end
      ST_INIT_HI: begin
        w_iocs   = 1'b1;
        w_iorw   = 1'b0;
        w_ioaddr = IOADDR_DIV_HI;
        w_dout   = w_div[15:8];
      end
      ST_READ: begin
        w_iocs   = 1'b1;
        w_iorw   = 1'b1;
        w_ioaddr = IOADDR_BUF;
      end
      ST_WRITE: begin
        w_iocs   = 1'b1;
        w_iorw   = 1'b0;
        w_ioaddr = IOADDR_BUF;
        w_dout   = w_fifo_head;
      end
      default: begin
        w_iocs   = 1'b0;
        w_iorw   = 1'b1;
        w_ioaddr = IOADDR_BUF;
        w_dout   = 8'h00;
      end
    endcase
  end

  // State, return state, captured baud select and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_INIT_LO;
      r_ret    <= ST_INIT_HI;
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= IOADDR_BUF;
      r_dout   <= 8'h00;
      r_br_q   <= 2'b00;
    end else begin
      r_state  <= w_next;
      r_ret    <= w_ret_next;
      r_iocs   <= w_iocs;
      r_iorw   <= w_iorw;
      r_ioaddr <= w_ioaddr;
      r_dout   <= w_dout;
      if (w_capture_br) begin
        r_br_q <= br_cfg;
      end
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// -----------------------------------------------------------------------------
// tb_spart_driver
// Directed bench for spart_driver. A tiny spart model supplies received bytes
// on reads and drops rda when its queue empties; tbr is driven directly.
// The bus is pulled up so an undriven databus reads 8'hFF.
// -----------------------------------------------------------------------------
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  wire        iocs;
  wire        iorw;
  wire  [1:0] ioaddr;
  wire  [7:0] databus;

  logic [7:0] rxq[$];
  logic [7:0] rx_head;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  logic       prev_iocs;
  logic       cur_iocs;
  logic       cur_rw;
  logic [1:0] cur_addr;
  logic [7:0] cur_data;
  logic       br_on_write_en;
  logic [1:0] br_on_write;
  logic       rst_on_read;
  logic       reset_hit;

  always #5 clk = ~clk;

  spart_driver #(.CLK_HZ(100_000_000), .DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr)
  );

  // spart side of the bus: answers buffer reads with its head byte
  assign databus = (iocs === 1'b1 && iorw === 1'b1 && ioaddr === 2'b00) ? rx_head : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (databus[g]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rx_load(input logic [7:0] b);
    rxq.push_back(b);
    rx_head = rxq[0];
    rda     = 1'b1;
  endtask

  // One clock: sample and police the bus mid-cycle, then update the spart model.
  task automatic tick();
    @(negedge clk);
    cur_iocs = iocs;
    cur_rw   = iorw;
    cur_addr = ioaddr;
    cur_data = databus;
    if (cur_iocs !== 1'b1) begin
      check("bus_released", cur_data, 8'hFF);
    end else begin
      check("access_spacing", {7'd0, prev_iocs}, 8'h00);
      if (cur_rw === 1'b1) check("read_no_contention", cur_data, rx_head);
    end
    prev_iocs = cur_iocs;
    if (cur_iocs === 1'b1 && cur_rw === 1'b0 && cur_addr === 2'b00 && br_on_write_en) begin
      br_cfg         = br_on_write;
      br_on_write_en = 1'b0;
    end
    if (cur_iocs === 1'b1 && cur_rw === 1'b1 && rst_on_read) begin
      rst         = 1'b0;
      rst_on_read = 1'b0;
      #1;
      check("rst_iocs_drop", {7'd0, iocs}, 8'h00);
      check("rst_bus_release", databus, 8'hFF);
      reset_hit = 1'b1;
      prev_iocs = 1'b0;
    end
    @(posedge clk);
    #1;
    if (cur_iocs === 1'b1 && cur_rw === 1'b1 && rst === 1'b1 && rxq.size() > 0) begin
      void'(rxq.pop_front());
    end
    rx_head = (rxq.size() > 0) ? rxq[0] : 8'h00;
    rda     = (rxq.size() > 0);
  endtask

  // Wait (bounded) for the next access and compare it; gap_exp=0 skips the spacing check.
  task automatic expect_acc(input string tag, input logic rw, input logic [1:0] addr,
                            input logic [7:0] data, input int gap_exp);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = (cur_iocs === 1'b1);
    end
    check({tag, "_seen"}, {7'd0, seen}, 8'h01);
    if (seen) begin
      check({tag, "_rw"}, {7'd0, cur_rw}, {7'd0, rw});
      check({tag, "_addr"}, {6'd0, cur_addr}, {6'd0, addr});
      check({tag, "_data"}, cur_data, data);
      if (gap_exp > 0) check({tag, "_gap"}, n[7:0], gap_exp[7:0]);
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check(tag, {7'd0, cur_iocs}, 8'h00);
    end
  endtask

  initial begin
    rst            = 1'b0;
    br_cfg         = 2'b01;
    rda            = 1'b0;
    tbr            = 1'b1;
    rx_head        = 8'h00;
    prev_iocs      = 1'b0;
    br_on_write_en = 1'b0;
    br_on_write    = 2'b00;
    rst_on_read    = 1'b0;
    reset_hit      = 1'b0;

    // Reset state
    repeat (3) tick();
    check("reset_iocs", {7'd0, iocs}, 8'h00);
    check("reset_iorw", {7'd0, iorw}, 8'h01);
    check("reset_ioaddr", {6'd0, ioaddr}, 8'h00);
    check("reset_databus", databus, 8'hFF);
    rst = 1'b1;

    // 1: divisor 9600 = 16'h028A, low then high, one gap between
    expect_acc("t1_div_lo", 1'b0, 2'b10, 8'h8A, 0);
    expect_acc("t1_div_hi", 1'b0, 2'b11, 8'h02, 2);
    quiet("t1_idle", 6);

    // 2: single echo, write two cycles after the read
    rx_load(8'h41);
    expect_acc("t2_read", 1'b1, 2'b00, 8'h41, 0);
    expect_acc("t2_write", 1'b0, 2'b00, 8'h41, 2);
    quiet("t2_idle", 5);

    // 3: fill the FIFO with tbr low, fifth byte stays in the spart
    tbr = 1'b0;
    rx_load("a"); rx_load("b"); rx_load("c"); rx_load("d"); rx_load("e");
    expect_acc("t3_rd_a", 1'b1, 2'b00, "a", 0);
    expect_acc("t3_rd_b", 1'b1, 2'b00, "b", 2);
    expect_acc("t3_rd_c", 1'b1, 2'b00, "c", 2);
    expect_acc("t3_rd_d", 1'b1, 2'b00, "d", 2);
    quiet("t3_full_hold", 6);
    tbr = 1'b1;
    expect_acc("t3_wr_a", 1'b0, 2'b00, "a", 0);
    expect_acc("t3_rd_e", 1'b1, 2'b00, "e", 2);
    expect_acc("t3_wr_b", 1'b0, 2'b00, "b", 2);
    expect_acc("t3_wr_c", 1'b0, 2'b00, "c", 2);
    expect_acc("t3_wr_d", 1'b0, 2'b00, "d", 2);
    expect_acc("t3_wr_e", 1'b0, 2'b00, "e", 2);
    quiet("t3_drained", 5);

    // 4: baud change to 38400 (16'h00A1) during a write; queued byte follows
    tbr = 1'b0;
    rx_load("x"); rx_load("y");
    expect_acc("t4_rd_x", 1'b1, 2'b00, "x", 0);
    expect_acc("t4_rd_y", 1'b1, 2'b00, "y", 2);
    quiet("t4_hold", 3);
    br_on_write    = 2'b11;
    br_on_write_en = 1'b1;
    tbr            = 1'b1;
    expect_acc("t4_wr_x", 1'b0, 2'b00, "x", 0);
    expect_acc("t4_div_lo", 1'b0, 2'b10, 8'hA1, 2);
    expect_acc("t4_div_hi", 1'b0, 2'b11, 8'h00, 2);
    expect_acc("t4_wr_y", 1'b0, 2'b00, "y", 2);
    quiet("t4_idle", 5);

    // 5: reset in the middle of a read; FIFO must come back empty
    tbr = 1'b0;
    rx_load("q");
    expect_acc("t5_rd_q", 1'b1, 2'b00, "q", 0);
    quiet("t5_hold", 3);
    rx_load("z");
    rst_on_read = 1'b1;
    for (int i = 0; i < 20 && !reset_hit; i++) tick();
    check("t5_reset_during_read", {7'd0, reset_hit}, 8'h01);
    rst_on_read = 1'b0;
    repeat (2) tick();
    rxq.delete();
    rx_head = 8'h00;
    rda     = 1'b0;
    rst     = 1'b1;
    tbr     = 1'b1;
    expect_acc("t5_div_lo", 1'b0, 2'b10, 8'hA1, 0);
    expect_acc("t5_div_hi", 1'b0, 2'b11, 8'h00, 2);
    quiet("t5_fifo_empty", 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
